yuv_pkt_scheduler: RTL and testbench
====================================

Name: yuv_pkt_scheduler

Overview:
- Shares one output formatter between NUM_CH camera pixel streams.
- Grants one channel per 128-pixel packet (round-robin), so a 3072-bit packet never mixes channels.
- Zero-pads a packet that is cut short by end-of-frame.
- Sits between the per-channel YUV2RGB converters and the formatter; tags each emitted packet with channel ID and frame-end status.

Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- PKT_PIXELS, 128: pixels per formatter packet; must match the formatter.
- PIX_W, 24: pixel width, {R,G,B} 8 bits each.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset; the formatter's rst_n is driven by ~rst at top level.
- ch_valid  in  NUM_CH  per-channel pixel valid.
- ch_pixel  in  NUM_CH*PIX_W  per-channel pixel; channel i occupies [i*PIX_W +: PIX_W].
- ch_last  in  NUM_CH  per-channel end-of-frame marker; qualified by the transfer.
- ch_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- stall  in  1  downstream hold; pauses pixel issue at any cycle.
- fmt_R / fmt_G / fmt_B  out  8 each  pixel to the formatter.
- fmt_valid  out  1  formatter valid_in.
- pkt_ch_id  out  $clog2(NUM_CH)  channel of the packet the formatter is about to emit.
- pkt_eof  out  1  that packet closes a frame.
- pkt_pad_cnt  out  8  number of zero pad pixels in that packet.
- pkt_total  out  16  count of packets issued; wraps.

Behaviour:
- Reset values:
  - ch_ready = 0, fmt_* = 0, fmt_valid = 0.
  - pkt_ch_id = 0, pkt_eof = 0, pkt_pad_cnt = 0, pkt_total = 0.
  - state = IDLE, pix_cnt = 0, last_grant = NUM_CH-1, so ch0 wins first.
- State IDLE:
  - If !stall and any ch_valid, grant the first requester after last_grant (cyclic).
  - grant is registered; move to STREAM next cycle. pix_cnt = 0.
- State STREAM:
  - ch_ready[grant] = !stall, combinational from registered state/grant. All other ch_ready bits are 0.
  - Transfer = ch_valid[grant] & ch_ready[grant].
  - On transfer: fmt_{R,G,B} <= pixel and fmt_valid <= 1 (latency 1 cycle); pix_cnt++.
  - No transfer → fmt_valid <= 0. The grant is held indefinitely; there is no timeout.
  - Transfer with pix_cnt == PKT_PIXELS-1 → IDLE, last_grant <= grant. ch_last on this same pixel needs no pad.
  - Transfer with ch_last and pix_cnt < PKT_PIXELS-1 → PAD.
- State PAD:
  - Each !stall cycle: fmt pixel = 0, fmt_valid = 1, pix_cnt++, pad counter++.
  - ch_ready = 0.
  - When pix_cnt reaches PKT_PIXELS-1 → IDLE, last_grant <= grant.
- stall:
  - Forces fmt_valid = 0 on the following cycle.
  - Gates ch_ready and pad issue, and blocks new grants. The formatter tolerates gaps.
- Packet metadata:
  - Updated on the cycle the final (PKT_PIXELS-th) pixel is registered onto fmt_*.
  - pkt_ch_id <= grant; pkt_eof <= eof-seen; pkt_pad_cnt <= pad count; pkt_total++.
  - Metadata is stable when the formatter asserts valid_out, one cycle after its final valid_in.
  - It holds ≥PKT_PIXELS cycles, until the next packet completes.
- Minimum gap: one IDLE cycle between packets. Peak throughput is PKT_PIXELS/(PKT_PIXELS+1).
- Simultaneous requests are resolved round-robin only; there is no priority.
- ch_valid dropping mid-packet: the grant is kept and the scheduler waits.
- Reset mid-operation: the partial packet is discarded and all state returns to reset values. The formatter resets with it.
- Width rules:
  - pix_cnt is 8 bits and compares against PKT_PIXELS-1.
  - pkt_total wraps 0xFFFF → 0.

Decomposition:
- Package yuv_sched_pkg:
  - PKT_PIXELS and PIX_W constants.
  - rgb_pixel_t (packed struct r, g, b).
  - sched_state_e enum {IDLE, STREAM, PAD}.
- Sub-module rr_arbiter:
  - Inputs: req[NUM_CH], last_grant.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational.

Test Plan:
1. ch0 only, 128 contiguous pixels 0x000001..0x000080, no stall → 128 fmt_valid pulses starting 1 cycle after first transfer. pkt_ch_id = 0, pkt_eof = 0, pkt_pad_cnt = 0, pkt_total = 1.
2. All 4 channels requesting continuously, 8 packets → grant order 0,1,2,3,0,1,2,3. Exactly one IDLE cycle between packets; no channel's pixels in another's packet.
3. ch2 sends 100 pixels with ch_last on pixel 100 → 28 zero pixels follow with fmt_valid = 1. pkt_ch_id = 2, pkt_eof = 1, pkt_pad_cnt = 28.
4. ch_last on pixel 128 → no PAD state entered. pkt_eof = 1, pkt_pad_cnt = 0.
5. stall asserted for 10 cycles at pixel 50, and for 5 cycles during PAD → no fmt_valid during stall (plus 1 cycle lag). Packet content identical to the unstalled case; ch_ready = 0 while stalled.
6. rst pulsed at pixel 60 of ch1's packet → all outputs at reset values immediately. After release, ch0 granted first; pkt_total = 0.

Source files
------------

// File: rtl/yuv_sched_pkg.sv
// Shared types and constants for the YUV packet scheduler.
package yuv_sched_pkg;

  localparam int unsigned PKT_PIXELS = 128;
  localparam int unsigned PIX_W      = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant, cyclically.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx,
  output logic                      any
);

  localparam int unsigned IdxW = $clog2(NUM_CH);

  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      cand     = (32'(last_grant) + off) % NUM_CH;
      cand_idx = cand[IdxW-1:0];
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/yuv_pkt_scheduler.sv
// Shares one output formatter between NUM_CH pixel streams, one channel per packet,
// zero-padding packets cut short by end-of-frame and tagging each with its metadata.
module yuv_pkt_scheduler
  import yuv_sched_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PKT_PIXELS = yuv_sched_pkg::PKT_PIXELS,
  parameter int unsigned PIX_W      = yuv_sched_pkg::PIX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH*PIX_W-1:0]   ch_pixel,
  input  logic [NUM_CH-1:0]         ch_last,
  output logic [NUM_CH-1:0]         ch_ready,
  input  logic                      stall,
  output logic [7:0]                fmt_R,
  output logic [7:0]                fmt_G,
  output logic [7:0]                fmt_B,
  output logic                      fmt_valid,
  output logic [$clog2(NUM_CH)-1:0] pkt_ch_id,
  output logic                      pkt_eof,
  output logic [7:0]                pkt_pad_cnt,
  output logic [15:0]               pkt_total
);

  localparam int unsigned IdxW    = $clog2(NUM_CH);
  localparam logic [7:0]  LastPix = 8'(PKT_PIXELS - 1);

  sched_state_e    state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [7:0]      pix_cnt_q, pix_cnt_d;
  logic [7:0]      pad_cnt_q, pad_cnt_d;
  logic            eof_q, eof_d;
  rgb_pixel_t      fmt_pix_q, fmt_pix_d;
  logic            fmt_valid_q, fmt_valid_d;
  logic [IdxW-1:0] pkt_ch_id_q, pkt_ch_id_d;
  logic            pkt_eof_q, pkt_eof_d;
  logic [7:0]      pkt_pad_q, pkt_pad_d;
  logic [15:0]     pkt_total_q, pkt_total_d;

  logic [NUM_CH-1:0] arb_grant;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_any;
  rgb_pixel_t        gnt_pix;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req        (ch_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  assign gnt_pix = ch_pixel[grant_q*PIX_W +: PIX_W];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pix_cnt_d    = pix_cnt_q;
    pad_cnt_d    = pad_cnt_q;
    eof_d        = eof_q;
    fmt_pix_d    = fmt_pix_q;
    fmt_valid_d  = 1'b0;
    pkt_ch_id_d  = pkt_ch_id_q;
    pkt_eof_d    = pkt_eof_q;
    pkt_pad_d    = pkt_pad_q;
    pkt_total_d  = pkt_total_q;
    ch_ready     = '0;

    unique case (state_q)
      IDLE: begin
        if (!stall && arb_any) begin
          grant_d   = arb_idx;
          state_d   = STREAM;
          pix_cnt_d = '0;
          pad_cnt_d = '0;
          eof_d     = 1'b0;
        end
      end
      STREAM: begin
        ch_ready[grant_q] = !stall;
        if (ch_valid[grant_q] && !stall) begin
          fmt_pix_d   = gnt_pix;
          fmt_valid_d = 1'b1;
          pix_cnt_d   = pix_cnt_q + 8'd1;
          if (pix_cnt_q == LastPix) begin
            // Frame end on the final pixel closes the packet without padding.
            state_d      = IDLE;
            last_grant_d = grant_q;
            pkt_ch_id_d  = grant_q;
            pkt_eof_d    = ch_last[grant_q];
            pkt_pad_d    = '0;
            pkt_total_d  = pkt_total_q + 16'd1;
          end else if (ch_last[grant_q]) begin
            state_d = PAD;
            eof_d   = 1'b1;
          end
        end
      end
      PAD: begin
        if (!stall) begin
          fmt_pix_d   = '0;
          fmt_valid_d = 1'b1;
          pix_cnt_d   = pix_cnt_q + 8'd1;
          pad_cnt_d   = pad_cnt_q + 8'd1;
          if (pix_cnt_q == LastPix) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            pkt_ch_id_d  = grant_q;
            pkt_eof_d    = eof_q;
            pkt_pad_d    = pad_cnt_q + 8'd1;
            pkt_total_d  = pkt_total_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IdxW'(NUM_CH - 1);
      pix_cnt_q    <= '0;
      pad_cnt_q    <= '0;
      eof_q        <= 1'b0;
      fmt_pix_q    <= '0;
      fmt_valid_q  <= 1'b0;
      pkt_ch_id_q  <= '0;
      pkt_eof_q    <= 1'b0;
      pkt_pad_q    <= '0;
      pkt_total_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pix_cnt_q    <= pix_cnt_d;
      pad_cnt_q    <= pad_cnt_d;
      eof_q        <= eof_d;
      fmt_pix_q    <= fmt_pix_d;
      fmt_valid_q  <= fmt_valid_d;
      pkt_ch_id_q  <= pkt_ch_id_d;
      pkt_eof_q    <= pkt_eof_d;
      pkt_pad_q    <= pkt_pad_d;
      pkt_total_q  <= pkt_total_d;
    end
  end

  assign fmt_R       = fmt_pix_q.r;
  assign fmt_G       = fmt_pix_q.g;
  assign fmt_B       = fmt_pix_q.b;
  assign fmt_valid   = fmt_valid_q;
  assign pkt_ch_id   = pkt_ch_id_q;
  assign pkt_eof     = pkt_eof_q;
  assign pkt_pad_cnt = pkt_pad_q;
  assign pkt_total   = pkt_total_q;

endmodule

// File: tb/tb_yuv_pkt_scheduler.sv
// Directed bench for yuv_pkt_scheduler with a packet-level reference model.
`timescale 1ns/1ps
module tb_yuv_pkt_scheduler;

  localparam int NCH = 4;
  localparam int PKT = 128;
  localparam int PW  = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_valid, ch_last, ch_ready;
  logic [NCH*PW-1:0] ch_pixel;
  logic              stall;
  logic [7:0]        fmt_R, fmt_G, fmt_B;
  logic              fmt_valid;
  logic [1:0]        pkt_ch_id;
  logic              pkt_eof;
  logic [7:0]        pkt_pad_cnt;
  logic [15:0]       pkt_total;

  yuv_pkt_scheduler #(
    .NUM_CH     (NCH),
    .PKT_PIXELS (PKT),
    .PIX_W      (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_pixel    (ch_pixel),
    .ch_last     (ch_last),
    .ch_ready    (ch_ready),
    .stall       (stall),
    .fmt_R       (fmt_R),
    .fmt_G       (fmt_G),
    .fmt_B       (fmt_B),
    .fmt_valid   (fmt_valid),
    .pkt_ch_id   (pkt_ch_id),
    .pkt_eof     (pkt_eof),
    .pkt_pad_cnt (pkt_pad_cnt),
    .pkt_total   (pkt_total)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source and model queues; bit 24 marks end-of-frame.
  logic [24:0] src_q [NCH][$];
  logic [24:0] mdl_q [NCH][$];
  int          pop_cnt [NCH];
  bit          stall_req = 1'b0;
  logic [NCH-1:0] fire_s;

  initial begin
    ch_valid = '0;
    ch_pixel = '0;
    ch_last  = '0;
    stall    = 1'b0;
    forever begin
      @(negedge clk);
      fire_s = (rst === 1'b1) ? '0 : (ch_valid & ch_ready);
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (fire_s[c] && src_q[c].size() > 0) begin
          void'(src_q[c].pop_front());
          pop_cnt[c]++;
        end
        ch_valid[c]             = src_q[c].size() > 0;
        ch_pixel[c*PW +: PW]    = ch_valid[c] ? src_q[c][0][23:0] : 24'h0;
        ch_last[c]              = ch_valid[c] ? src_q[c][0][24] : 1'b0;
      end
      stall = stall_req;
    end
  end

  // Packet-level model: each packet belongs to the next channel with data after the
  // previous winner, carries up to PKT pixels until end-of-frame, then zeros.
  logic [23:0] exp_pix [PKT];
  int k_idx = 0;
  bit in_pkt = 0;
  int mdl_last = NCH - 1;
  int cur_ch = 0, cur_pad = 0;
  bit cur_eof = 0;
  int md_ch = 0, md_pad = 0, mdl_total = 0;
  bit md_eof = 0;
  bit prev_stall = 0, prev_fire = 0;
  int gap = 0;
  bit check_gap = 0, gap_armed = 0;
  int pkts_done = 0;
  int order[$];

  task automatic start_pkt();
    bit found = 0;
    int c;
    logic [24:0] e;
    for (int off = 1; off <= NCH; off++) begin
      c = (mdl_last + off) % NCH;
      if (!found && mdl_q[c].size() > 0) begin
        found  = 1;
        cur_ch = c;
      end
    end
    chk("grant_has_data", 32'(found), 32'd1);
    cur_pad = 0;
    cur_eof = 0;
    for (int k = 0; k < PKT; k++) begin
      if (found && !cur_eof && mdl_q[cur_ch].size() > 0) begin
        e          = mdl_q[cur_ch].pop_front();
        exp_pix[k] = e[23:0];
        cur_eof    = e[24];
      end else begin
        exp_pix[k] = 24'h0;
        cur_pad++;
      end
    end
    if (check_gap && gap_armed) chk("idle_gap", 32'(gap), 32'd1);
    in_pkt = 1;
    k_idx  = 0;
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      in_pkt = 0; k_idx = 0; mdl_last = NCH - 1;
      md_ch = 0; md_eof = 0; md_pad = 0; mdl_total = 0;
      prev_stall = 0; prev_fire = 0; gap = 0; gap_armed = 0;
    end else begin
      if (!check_gap) gap_armed = 0;
      chk("ready_onehot0", 32'($countones(ch_ready) <= 1), 32'd1);
      if (stall) chk("ready_while_stall", 32'(ch_ready), 32'd0);
      if (prev_stall) chk("valid_after_stall", 32'(fmt_valid), 32'd0);
      if (prev_fire) chk("valid_after_xfer", 32'(fmt_valid), 32'd1);
      if (fmt_valid) begin
        if (!in_pkt) start_pkt();
        chk("pixel", 32'({fmt_R, fmt_G, fmt_B}), 32'(exp_pix[k_idx]));
        k_idx++;
        if (k_idx == PKT) begin
          in_pkt    = 0;
          md_ch     = cur_ch;
          md_eof    = cur_eof;
          md_pad    = cur_pad;
          mdl_total = (mdl_total + 1) & 32'hFFFF;
          mdl_last  = cur_ch;
          order.push_back(int'(pkt_ch_id));
          pkts_done++;
          gap       = 0;
          gap_armed = check_gap;
        end
      end else begin
        gap++;
      end
      chk("pkt_total", 32'(pkt_total), 32'(mdl_total));
      chk("pkt_ch_id", 32'(pkt_ch_id), 32'(md_ch));
      chk("pkt_eof", 32'(pkt_eof), 32'(md_eof));
      chk("pkt_pad_cnt", 32'(pkt_pad_cnt), 32'(md_pad));
      prev_stall = stall;
      prev_fire  = |(ch_valid & ch_ready);
    end
  end

  task automatic load(input int c, input int n, input int base, input bit last_at_end);
    logic [24:0] e;
    for (int i = 0; i < n; i++) begin
      e = {last_at_end && (i == n - 1), 24'(base + i)};
      src_q[c].push_back(e);
      mdl_q[c].push_back(e);
    end
  endtask

  task automatic wait_pkts(input int target, input int budget, input string name);
    int cyc = 0;
    while (pkts_done < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done_in_time"}, 32'(pkts_done >= target), 32'd1);
  endtask

  task automatic wait_pops(input int c, input int n, input int budget);
    int cyc = 0;
    while (pop_cnt[c] < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("pops_in_time", 32'(pop_cnt[c] >= n), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst       = 1'b1;
    stall_req = 1'b0;
    #1;
    chk("rst_ch_ready", 32'(ch_ready), 32'd0);
    chk("rst_fmt_valid", 32'(fmt_valid), 32'd0);
    chk("rst_fmt_pix", 32'({fmt_R, fmt_G, fmt_B}), 32'd0);
    chk("rst_pkt_meta", 32'({pkt_ch_id, pkt_eof, pkt_pad_cnt}), 32'd0);
    chk("rst_pkt_total", 32'(pkt_total), 32'd0);
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete();
      mdl_q[c].delete();
      pop_cnt[c] = 0;
    end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int b;
    int cyc;
    rst = 1'b1;
    do_reset();

    // 1: single channel, one full packet
    @(posedge clk); #2;
    load(0, 128, 1, 1'b0);
    wait_pkts(1, 400, "t1");
    chk("t1_ch_id", 32'(pkt_ch_id), 32'd0);
    chk("t1_eof", 32'(pkt_eof), 32'd0);
    chk("t1_pad", 32'(pkt_pad_cnt), 32'd0);
    chk("t1_total", 32'(pkt_total), 32'd1);

    // 2: all channels requesting, fresh arbitration
    do_reset();
    b = pkts_done;
    check_gap = 1;
    @(posedge clk); #2;
    for (int c = 0; c < NCH; c++) load(c, 256, (c + 1) << 16, 1'b0);
    wait_pkts(b + 8, 8 * 140 + 50, "t2");
    check_gap = 0;
    for (int i = 0; i < 8; i++)
      chk("t2_order", 32'((order.size() > b + i) ? order[b + i] : 99), 32'(i % 4));
    chk("t2_total", 32'(pkt_total), 32'd8);

    // 3: short frame on ch2, padded
    @(posedge clk); #2;
    load(2, 100, 24'h300001, 1'b1);
    wait_pkts(b + 9, 400, "t3");
    chk("t3_ch_id", 32'(pkt_ch_id), 32'd2);
    chk("t3_eof", 32'(pkt_eof), 32'd1);
    chk("t3_pad", 32'(pkt_pad_cnt), 32'd28);
    chk("t3_total", 32'(pkt_total), 32'd9);

    // 4: frame end lands on the final pixel
    @(posedge clk); #2;
    load(3, 128, 24'h400001, 1'b1);
    wait_pkts(b + 10, 400, "t4");
    chk("t4_ch_id", 32'(pkt_ch_id), 32'd3);
    chk("t4_eof", 32'(pkt_eof), 32'd1);
    chk("t4_pad", 32'(pkt_pad_cnt), 32'd0);

    // 5: stalls mid-stream and during padding
    @(posedge clk); #2;
    load(1, 90, 24'h500001, 1'b1);
    wait_pops(1, 50, 400);
    stall_req = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t5_ready_stalled", 32'(ch_ready), 32'd0);
    chk("t5_valid_stalled", 32'(fmt_valid), 32'd0);
    stall_req = 1'b0;
    cyc = 0;
    while (src_q[1].size() > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_drained", 32'(src_q[1].size()), 32'd0);
    repeat (3) @(posedge clk);
    stall_req = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_pad_stalled", 32'(fmt_valid), 32'd0);
    stall_req = 1'b0;
    wait_pkts(b + 11, 400, "t5");
    chk("t5_ch_id", 32'(pkt_ch_id), 32'd1);
    chk("t5_eof", 32'(pkt_eof), 32'd1);
    chk("t5_pad", 32'(pkt_pad_cnt), 32'd38);

    // 6: reset in the middle of ch1's packet
    @(posedge clk); #2;
    load(1, 200, 24'h600001, 1'b0);
    wait_pops(1, 60, 400);
    do_reset();
    b = pkts_done;
    @(posedge clk); #2;
    load(0, 128, 24'h700001, 1'b0);
    load(1, 128, 24'h710001, 1'b0);
    wait_pkts(b + 2, 600, "t6");
    chk("t6_first", 32'((order.size() > b) ? order[b] : 99), 32'd0);
    chk("t6_second", 32'((order.size() > b + 1) ? order[b + 1] : 99), 32'd1);
    chk("t6_total", 32'(pkt_total), 32'd2);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
